// File: rtl/filter_pkg.sv
// filter_pkg: shared sample/word types and FSM encoding for the sample feeder.
package filter_pkg;
  typedef logic [1:0] sample_t;
  typedef logic [7:0] word_t;
  localparam int SamplesPerWord = 4;
  typedef enum logic {FeedIdle, FeedShift} feed_state_e;
endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: small word FIFO with occupancy count; push is refused when full.
module sample_fifo
  import filter_pkg::*;
#(
  parameter int Depth = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push,
  input  word_t                      wdata,
  input  logic                       pop,
  output word_t                      rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(Depth+1)-1:0] fill
);
  localparam int AW = $clog2(Depth);
  localparam int FW = $clog2(Depth + 1);
  word_t mem [Depth];
  logic [AW-1:0] wptr, rptr;
  logic do_push, do_pop;
  assign full    = fill == FW'(Depth);
  assign empty   = fill == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];
  always_ff @(posedge clk_i)
    if (do_push) mem[wptr] <= wdata;
  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr <= '0;
      rptr <= '0;
      fill <= '0;
    end else begin
      wptr <= do_push ? wptr + AW'(1) : wptr;
      rptr <= do_pop ? rptr + AW'(1) : rptr;
      fill <= fill + FW'(do_push) - FW'(do_pop);
    end
  end
endmodule

// File: rtl/sample_feeder.sv
// sample_feeder: buffers packed words and feeds one 2-bit sample per rate tick
// to the FIR filter, pulsing underrun when a tick finds nothing to send.
module sample_feeder
  import filter_pkg::*;
#(
  parameter int Depth   = 4,
  parameter int RateDiv = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       enable_i,
  input  word_t                      in_data_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  output logic                       data_out_req_o,
  output sample_t                    data_out_o,
  output logic                       underrun_o,
  output logic [$clog2(Depth+1)-1:0] fill_o
);
  localparam int CW = RateDiv > 1 ? $clog2(RateDiv) : 1;
  logic [CW-1:0] cnt;
  logic tick, full, empty, pop, last, shift_tick;
  word_t fifo_data, word_q;
  logic [1:0] idx_q;
  feed_state_e state;
  assign tick       = enable_i && cnt == CW'(RateDiv - 1);
  assign last       = idx_q == 2'(SamplesPerWord - 1);
  assign shift_tick = state == FeedShift && tick;
  // IDLE loads eagerly; SHIFT reloads only as the last sample goes out.
  assign pop        = !empty && (state == FeedIdle || (tick && last));
  assign in_ready_o = !full;

  sample_fifo #(.Depth(Depth)) u_fifo (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .push  (in_valid_i),
    .wdata (in_data_i),
    .pop   (pop),
    .rdata (fifo_data),
    .full  (full),
    .empty (empty),
    .fill  (fill_o)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt <= '0;
    else cnt <= (enable_i && !tick) ? cnt + 1'b1 : '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state          <= FeedIdle;
      word_q         <= '0;
      idx_q          <= '0;
      data_out_o     <= '0;
      data_out_req_o <= 1'b0;
      underrun_o     <= 1'b0;
    end else begin
      data_out_req_o <= shift_tick;
      underrun_o     <= state == FeedIdle && tick;
      if (shift_tick) data_out_o <= word_q[{idx_q, 1'b0} +: 2];
      if (pop) begin
        word_q <= fifo_data;
        idx_q  <= '0;
        state  <= FeedShift;
      end else if (shift_tick) begin
        idx_q <= idx_q + 1'b1;
        if (last) state <= FeedIdle;
      end
    end
  end
endmodule

// File: tb/tb_sample_feeder.sv
// tb_sample_feeder: scoreboard bench for two feeder instances (RateDiv 1 and 4).
module tb_sample_feeder;
  import filter_pkg::*;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst_n1 = 1'b0, en1 = 1'b0, v1 = 1'b0;
  logic rst_n4 = 1'b0, en4 = 1'b0, v4 = 1'b0;
  word_t d1 = '0, d4 = '0;
  logic rdy1, req1, ur1_o, rdy4, req4, ur4_o;
  sample_t dout1, dout4;
  logic [2:0] fill1, fill4;

  sample_feeder #(.Depth(4), .RateDiv(1)) u1 (
    .clk_i(clk), .rst_ni(rst_n1), .enable_i(en1), .in_data_i(d1), .in_valid_i(v1),
    .in_ready_o(rdy1), .data_out_req_o(req1), .data_out_o(dout1), .underrun_o(ur1_o), .fill_o(fill1));
  sample_feeder #(.Depth(4), .RateDiv(4)) u4 (
    .clk_i(clk), .rst_ni(rst_n4), .enable_i(en4), .in_data_i(d4), .in_valid_i(v4),
    .in_ready_o(rdy4), .data_out_req_o(req4), .data_out_o(dout4), .underrun_o(ur4_o), .fill_o(fill4));

  typedef struct {int c; logic [1:0] s;} exp_t;
  exp_t q1[$], q4[$];
  int n_cmp = 0, n_err = 0, ur1 = 0, ur4 = 0;
  word_t ws [6] = '{8'h1E, 8'h2D, 8'h3C, 8'h4B, 8'h5A, 8'h69};
  word_t wr [4] = '{8'hC6, 8'h93, 8'hA5, 8'h0F};

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic exp_word(input bit four, input int first, input int step, input word_t w);
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      e.c = first + i * step;
      e.s = w[2*i +: 2];
      if (four) q4.push_back(e);
      else q1.push_back(e);
    end
  endtask

  task automatic at(input int c);
    while (cyc < c) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Pops the expected sample and strobe cycle whenever a DUT strobes.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (req1) begin
        if (q1.size() == 0) chk("dut1 unexpected strobe", cyc, -1);
        else begin
          e = q1.pop_front();
          chk("dut1 strobe cycle", cyc, e.c);
          chk("dut1 sample", int'(dout1), int'(e.s));
        end
      end
      if (req4) begin
        if (q4.size() == 0) chk("dut4 unexpected strobe", cyc, -1);
        else begin
          e = q4.pop_front();
          chk("dut4 strobe cycle", cyc, e.c);
          chk("dut4 sample", int'(dout4), int'(e.s));
        end
      end
      if (ur1_o) ur1++;
      if (ur4_o) ur4++;
    end
  endtask

  initial begin
    int t, p, c, e, e2, u0;
    fork monitor(); join_none
    at(2);
    chk("reset ready1", int'(rdy1), 1);
    chk("reset ready4", int'(rdy4), 1);
    chk("reset fill4", int'(fill4), 0);
    chk("reset req4", int'(req4), 0);
    chk("reset data4", int'(dout4), 0);
    chk("reset underrun4", int'(ur4_o), 0);
    at(3);
    rst_n1 = 1'b1;
    rst_n4 = 1'b1;
    en1 = 1'b1;
    // single word at RateDiv=1
    t = cyc + 2;
    at(t);
    exp_word(1'b0, t + 3, 1, 8'hE4);
    d1 = 8'hE4;
    v1 = 1'b1;
    at(t + 1);
    v1 = 1'b0;
    chk("dut1 fill after push", int'(fill1), 1);
    for (int k = 3; k <= 10; k++) begin
      at(t + k);
      chk("dut1 underrun window", int'(ur1_o), int'(k >= 7));
    end
    en1 = 1'b0;
    chk("dut1 queue drained", q1.size(), 0);
    // back-to-back words at RateDiv=4
    p = cyc + 1;
    at(p);
    d4 = 8'h1B;
    v4 = 1'b1;
    at(p + 1);
    d4 = 8'hFF;
    at(p + 2);
    v4 = 1'b0;
    at(p + 3);
    chk("b2b fill before enable", int'(fill4), 1);
    e = p + 4;
    at(e);
    en4 = 1'b1;
    u0 = ur4;
    exp_word(1'b1, e + 4, 4, 8'h1B);
    exp_word(1'b1, e + 20, 4, 8'hFF);
    at(e + 34);
    chk("b2b no underrun", ur4 - u0, 0);
    chk("b2b queue drained", q4.size(), 0);
    at(e + 37);
    chk("b2b underrun after drain", ur4 - u0, 1);
    en4 = 1'b0;
    // enable gating mid-word
    p = cyc + 1;
    at(p);
    d4 = 8'hE4;
    v4 = 1'b1;
    at(p + 1);
    v4 = 1'b0;
    e = p + 3;
    at(e);
    en4 = 1'b1;
    u0 = ur4;
    q4.push_back('{e + 4, 2'd0});
    q4.push_back('{e + 8, 2'd1});
    at(e + 9);
    en4 = 1'b0;
    at(e + 19);
    chk("gate no underrun", ur4 - u0, 0);
    chk("gate first half drained", q4.size(), 0);
    e2 = e + 19;
    en4 = 1'b1;
    q4.push_back('{e2 + 4, 2'd2});
    q4.push_back('{e2 + 8, 2'd3});
    at(e2 + 9);
    en4 = 1'b0;
    at(e2 + 10);
    chk("gate resume no underrun", ur4 - u0, 0);
    chk("gate queue drained", q4.size(), 0);
    // full FIFO with enable low, then simultaneous push/pop at fill 2
    c = cyc + 1;
    at(c);
    for (int i = 0; i < 5; i++) begin
      d4 = ws[i];
      v4 = 1'b1;
      chk("full ready while filling", int'(rdy4), 1);
      at(c + i + 1);
    end
    chk("full fill", int'(fill4), 4);
    chk("full ready", int'(rdy4), 0);
    d4 = ws[5];
    at(c + 10);
    chk("full sixth held ready", int'(rdy4), 0);
    chk("full sixth held fill", int'(fill4), 4);
    e = c + 10;
    en4 = 1'b1;
    u0 = ur4;
    for (int w = 0; w < 6; w++) exp_word(1'b1, e + 4 + 16 * w, 4, ws[w]);
    exp_word(1'b1, e + 100, 4, 8'h78);
    at(e + 16);
    chk("full ready after pop", int'(rdy4), 1);
    at(e + 17);
    v4 = 1'b0;
    chk("full sixth accepted", int'(fill4), 4);
    at(e + 63);
    chk("pushpop fill before", int'(fill4), 2);
    d4 = 8'h78;
    v4 = 1'b1;
    at(e + 64);
    v4 = 1'b0;
    chk("pushpop fill after", int'(fill4), 2);
    at(e + 113);
    chk("full no underrun", ur4 - u0, 0);
    chk("full queue drained", q4.size(), 0);
    en4 = 1'b0;
    // async reset mid-word
    c = cyc + 1;
    at(c);
    for (int i = 0; i < 4; i++) begin
      d4 = wr[i];
      v4 = 1'b1;
      at(c + i + 1);
    end
    v4 = 1'b0;
    chk("reset-test fill", int'(fill4), 3);
    e = c + 5;
    at(e);
    en4 = 1'b1;
    q4.push_back('{e + 4, 2'd2});
    q4.push_back('{e + 8, 2'd1});
    at(e + 9);
    rst_n4 = 1'b0;
    #1;
    chk("midreset req", int'(req4), 0);
    chk("midreset data", int'(dout4), 0);
    chk("midreset underrun", int'(ur4_o), 0);
    chk("midreset fill", int'(fill4), 0);
    chk("midreset ready", int'(rdy4), 1);
    at(e + 11);
    rst_n4 = 1'b1;
    at(e + 31);
    chk("postreset fill", int'(fill4), 0);
    chk("postreset queue", q4.size(), 0);
    en4 = 1'b0;
    p = cyc + 1;
    at(p);
    d4 = 8'h4E;
    v4 = 1'b1;
    at(p + 1);
    v4 = 1'b0;
    e = p + 3;
    at(e);
    en4 = 1'b1;
    exp_word(1'b1, e + 4, 4, 8'h4E);
    at(e + 17);
    en4 = 1'b0;
    chk("final q1 empty", q1.size(), 0);
    chk("final q4 empty", q4.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
